// File: rtl/password_store.sv
// Committed 4-digit password with a combinational read port, plus the
// programming sequencer that stages new digits and commits them atomically.
module password_store #(
  parameter int DEFAULT_PASSWORD_0 = 0,
  parameter int DEFAULT_PASSWORD_1 = 0,
  parameter int DEFAULT_PASSWORD_2 = 0,
  parameter int DEFAULT_PASSWORD_3 = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] address,
  output logic [3:0] data,
  input  logic       unlocked,
  input  logic       setReq,
  input  logic       digitValid,
  input  logic [3:0] digitIn,
  input  logic       confirm,
  input  logic       cancel,
  output logic       programming,
  output logic [2:0] progCount,
  output logic       progDone,
  output logic       progError
);

  typedef enum logic [1:0] {S_IDLE, S_ENTER, S_CONFIRM} state_t;

  state_t     state, state_next;
  logic [2:0] count, count_next;
  logic [3:0] shadow [4];
  logic [3:0] committed [4];
  logic       capture, commit_now;
  logic       done_next, error_next;
  logic       done_q, error_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state        <= S_IDLE;
      count        <= 3'd0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      shadow[0]    <= 4'd0;
      shadow[1]    <= 4'd0;
      shadow[2]    <= 4'd0;
      shadow[3]    <= 4'd0;
      committed[0] <= 4'(DEFAULT_PASSWORD_0);
      committed[1] <= 4'(DEFAULT_PASSWORD_1);
      committed[2] <= 4'(DEFAULT_PASSWORD_2);
      committed[3] <= 4'(DEFAULT_PASSWORD_3);
    end else begin
      state   <= state_next;
      count   <= count_next;
      done_q  <= done_next;
      error_q <= error_next;
      if (capture) shadow[count[1:0]] <= digitIn;
      if (commit_now) begin
        committed[0] <= shadow[0];
        committed[1] <= shadow[1];
        committed[2] <= shadow[2];
        committed[3] <= shadow[3];
      end
    end
  end

  // Cancel outranks lock loss, which outranks digit entry and confirm.
  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    commit_now = 1'b0;
    done_next  = 1'b0;
    error_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (setReq && unlocked) begin
          state_next = S_ENTER;
          count_next = 3'd0;
        end
      end
      S_ENTER: begin
        if (cancel) begin
          state_next = S_IDLE;
          count_next = 3'd0;
        end else if (!unlocked) begin
          state_next = S_IDLE;
          count_next = 3'd0;
          error_next = 1'b1;
        end else if (digitValid) begin
          if (digitIn <= 4'd9) begin
            capture    = 1'b1;
            count_next = (count >= 3'd4) ? 3'd4 : count + 3'd1;
            if (count == 3'd3) state_next = S_CONFIRM;
          end else begin
            state_next = S_IDLE;
            count_next = 3'd0;
            error_next = 1'b1;
          end
        end
      end
      S_CONFIRM: begin
        if (cancel) begin
          state_next = S_IDLE;
          count_next = 3'd0;
        end else if (!unlocked || digitValid) begin
          state_next = S_IDLE;
          count_next = 3'd0;
          error_next = 1'b1;
        end else if (confirm) begin
          state_next = S_IDLE;
          count_next = 3'd0;
          commit_now = 1'b1;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
        count_next = 3'd0;
      end
    endcase
  end

  always_comb begin
    programming = (state != S_IDLE);
    progCount   = count;
    progDone    = done_q;
    progError   = error_q;
    data        = committed[address];
  end

endmodule

// File: tb/tb_password_store.sv
// Bench for password_store: directed vector table, corner-case sequences and
// random traffic, all checked against a queue-based password model.
module tb_password_store;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [1:0] address = 2'd0;
  logic [3:0] data;
  logic       unlocked = 1'b0;
  logic       setReq = 1'b0;
  logic       digitValid = 1'b0;
  logic [3:0] digitIn = 4'd0;
  logic       confirm = 1'b0;
  logic       cancel = 1'b0;
  logic       programming;
  logic [2:0] progCount;
  logic       progDone;
  logic       progError;

  int vectors = 0;
  int miscompares = 0;

  // Model: an open programming session holds the digits typed so far.
  logic       mActive = 1'b0;
  logic [3:0] mDigits [$];
  logic [3:0] mCommitted [4] = '{4'd0, 4'd0, 4'd0, 4'd0};
  logic       mDone = 1'b0;
  logic       mError = 1'b0;

  password_store dut (
    .CLK(CLK), .RST(RST), .address(address), .data(data),
    .unlocked(unlocked), .setReq(setReq), .digitValid(digitValid),
    .digitIn(digitIn), .confirm(confirm), .cancel(cancel),
    .programming(programming), .progCount(progCount),
    .progDone(progDone), .progError(progError)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, unl, sr, dv;
    logic [3:0] di;
    logic       cf, cn;
    logic [1:0] ad;
    logic [3:0] expData;
    logic       expProg;
    logic [2:0] expCount;
    logic       expDone, expError;
  } vec_t;

  vec_t table_v [13];

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic modelStep(input logic rst, unl, sr, dv, input logic [3:0] di,
                           input logic cf, cn);
    mDone = 1'b0;
    mError = 1'b0;
    if (!rst) begin
      mActive = 1'b0;
      mDigits.delete();
      for (int i = 0; i < 4; i++) mCommitted[i] = 4'd0;
    end else if (mActive) begin
      if (cn) begin
        mActive = 1'b0;
        mDigits.delete();
      end else if (!unl) begin
        mError = 1'b1;
        mActive = 1'b0;
        mDigits.delete();
      end else if (dv) begin
        if (di > 4'd9 || mDigits.size() == 4) begin
          mError = 1'b1;
          mActive = 1'b0;
          mDigits.delete();
        end else begin
          mDigits.push_back(di);
        end
      end else if (cf && mDigits.size() == 4) begin
        for (int i = 0; i < 4; i++) mCommitted[i] = mDigits[i];
        mDone = 1'b1;
        mActive = 1'b0;
        mDigits.delete();
      end
    end else if (sr && unl) begin
      mActive = 1'b1;
      mDigits.delete();
    end
  endtask

  // Drive one cycle of inputs, advance the model, then check outputs after the edge.
  task automatic applyStimulus(input logic rst, unl, sr, dv, input logic [3:0] di,
                               input logic cf, cn, input logic [1:0] ad);
    RST = rst; unlocked = unl; setReq = sr; digitValid = dv;
    digitIn = di; confirm = cf; cancel = cn; address = ad;
    modelStep(rst, unl, sr, dv, di, cf, cn);
    @(posedge CLK);
    #1;
    checkOutput("data", int'(data), int'(mCommitted[ad]));
    checkOutput("programming", int'(programming), int'(mActive));
    checkOutput("progCount", int'(progCount), mDigits.size());
    checkOutput("progDone", int'(progDone), int'(mDone));
    checkOutput("progError", int'(progError), int'(mError));
  endtask

  task automatic idle(input logic unl, input logic [1:0] ad);
    applyStimulus(1'b1, unl, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, ad);
  endtask

  task automatic digit(input logic [3:0] d);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, d, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic startProg();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0);
  endtask

  task automatic confirmNow(input logic unl, input logic dv);
    applyStimulus(1'b1, unl, 1'b0, dv, 4'd2, 1'b1, 1'b0, 2'd0);
  endtask

  task automatic checkPassword(input string name, input logic [3:0] d0, d1, d2, d3);
    logic [3:0] want [4];
    want = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, 2'(i));
      checkOutput(name, int'(data), int'(want[i]));
    end
  endtask

  initial begin
    // rst unl sr dv di cf cn ad | data prog cnt done err
    table_v[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0};
    table_v[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd1, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0};
    table_v[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd2, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0};
    table_v[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd3, 4'd0, 1'b0, 3'd0, 1'b0, 1'b0};
    table_v[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 3'd0, 1'b0, 1'b0};
    table_v[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 3'd1, 1'b0, 1'b0};
    table_v[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 3'd2, 1'b0, 1'b0};
    table_v[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 3'd3, 1'b0, 1'b0};
    table_v[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 2'd0, 4'd0, 1'b1, 3'd4, 1'b0, 1'b0};
    table_v[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0, 4'd3, 1'b0, 3'd0, 1'b1, 1'b0};
    table_v[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd1, 4'd1, 1'b0, 3'd0, 1'b0, 1'b0};
    table_v[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd2, 4'd4, 1'b0, 3'd0, 1'b0, 1'b0};
    table_v[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd3, 4'd1, 1'b0, 3'd0, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      applyStimulus(table_v[i].rst, table_v[i].unl, table_v[i].sr, table_v[i].dv,
                    table_v[i].di, table_v[i].cf, table_v[i].cn, table_v[i].ad);
      checkOutput("tbl_data", int'(data), int'(table_v[i].expData));
      checkOutput("tbl_prog", int'(programming), int'(table_v[i].expProg));
      checkOutput("tbl_count", int'(progCount), int'(table_v[i].expCount));
      checkOutput("tbl_done", int'(progDone), int'(table_v[i].expDone));
      checkOutput("tbl_error", int'(progError), int'(table_v[i].expError));
    end

    // Invalid digit after two good ones aborts with an error.
    startProg();
    digit(4'd5);
    digit(4'd6);
    digit(4'hA);
    checkOutput("baddigit_err", int'(progError), 1);
    checkOutput("baddigit_cnt", int'(progCount), 0);
    checkOutput("baddigit_prog", int'(programming), 0);
    idle(1'b1, 2'd0);
    checkOutput("baddigit_pulse", int'(progError), 0);
    checkPassword("baddigit_keep", 4'd3, 4'd1, 4'd4, 4'd1);

    // Confirm in the same cycle the lock drops: error, no commit.
    startProg();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0);
    checkOutput("early_confirm_prog", int'(programming), 1);
    for (int i = 0; i < 4; i++) digit(4'd7);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0);
    checkOutput("setreq_in_confirm_cnt", int'(progCount), 4);
    confirmNow(1'b0, 1'b0);
    checkOutput("lockloss_err", int'(progError), 1);
    checkOutput("lockloss_done", int'(progDone), 0);
    checkOutput("lockloss_prog", int'(programming), 0);
    checkPassword("lockloss_keep", 4'd3, 4'd1, 4'd4, 4'd1);

    // Cancel together with lock loss is a silent abort.
    startProg();
    digit(4'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'd0);
    checkOutput("cancel_err", int'(progError), 0);
    checkOutput("cancel_prog", int'(programming), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0);
    checkOutput("locked_setreq", int'(programming), 0);
    checkOutput("locked_setreq_err", int'(progError), 0);

    // Commit 9999, then reset mid-programming restores defaults.
    startProg();
    for (int i = 0; i < 4; i++) digit(4'd9);
    confirmNow(1'b1, 1'b0);
    checkOutput("commit9_done", int'(progDone), 1);
    checkPassword("commit9", 4'd9, 4'd9, 4'd9, 4'd9);
    startProg();
    digit(4'd1);
    digit(4'd2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0);
    checkOutput("midreset_prog", int'(programming), 0);
    checkPassword("midreset", 4'd0, 4'd0, 4'd0, 4'd0);

    // Fifth digit, and confirm combined with a digit, both abort without commit.
    startProg();
    for (int i = 0; i < 4; i++) digit(4'd8);
    digit(4'd8);
    checkOutput("fifth_err", int'(progError), 1);
    startProg();
    for (int i = 0; i < 4; i++) digit(4'd6);
    confirmNow(1'b1, 1'b1);
    checkOutput("confirm_dv_err", int'(progError), 1);
    checkOutput("confirm_dv_done", int'(progDone), 0);
    checkPassword("fifth_keep", 4'd0, 4'd0, 4'd0, 4'd0);

    // Random traffic with strobes biased toward completing sessions.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom_range(0, 99) != 0),
                    ($urandom_range(0, 19) != 0),
                    ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9)),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 24) == 0),
                    2'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
